// File: rtl/pds_pkg.sv
// Shared types and widths for the PDS request arbiter: packet layout and FSM states.
package pds_pkg;

  localparam int SRC_W  = 4;
  localparam int TGT_W  = 4;
  localparam int DATA_W = 8;
  localparam int PKT_W  = SRC_W + TGT_W + DATA_W;

  typedef struct packed {
    logic [SRC_W-1:0]  source;
    logic [TGT_W-1:0]  target;
    logic [DATA_W-1:0] data;
  } pds_pkt_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    GAP       = 2'd3
  } pds_arb_state_e;

  // Index width for a requester count; at least one bit even for degenerate counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pds_rr_picker.sv
// Combinational round-robin selector: first set req bit at or above ptr, wrapping.
module pds_rr_picker
  import pds_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_any
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      pos_idx = IDX_W'(pos);
      if (!win_any && req[pos_idx]) begin
        win_any         = 1'b1;
        win_oh[pos_idx] = 1'b1;
        win_idx         = pos_idx;
      end
    end
  end

endmodule

// File: rtl/pds_arb.sv
// Round-robin sequencer sharing one PDS input port among N_REQ requesters,
// one outstanding packet at a time, with response routing and timeout.
module pds_arb
  import pds_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*PKT_W-1:0] pkt,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [PKT_W-1:0]       rsp_data,
  output logic [N_REQ-1:0]       timeout_err,
  output logic                   stray_err,
  output logic [PKT_W-1:0]       data_ip,
  output logic                   valid_up,
  input  logic [PKT_W-1:0]       data_op,
  input  logic                   valid_op,
  output logic                   busy
);

  localparam int IDX_W  = idx_w(N_REQ);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);

  pds_arb_state_e    state, next_state;
  logic [IDX_W-1:0]  ptr, owner, ptr_next;
  logic [TCNT_W-1:0] tcnt;
  logic              tcnt_done;

  logic [N_REQ-1:0]  win_oh, owner_oh;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  logic [PKT_W-1:0]  win_raw;
  pds_pkt_t          issue_pkt;

  logic [N_REQ-1:0]  gnt_d, rsp_valid_d, timeout_err_d;
  logic              valid_up_d, stray_d, capture_d;

  pds_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  // Winner's packet with the source field forced to the requester index.
  always_comb begin
    win_raw = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_raw = win_raw | (pkt[i*PKT_W +: PKT_W] & {PKT_W{win_oh[i]}});
    end
    issue_pkt        = pds_pkt_t'(win_raw);
    issue_pkt.source = SRC_W'(win_idx);
  end

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_oh[i] = (owner == IDX_W'(i));
    end
  end

  assign ptr_next  = (owner == IDX_LAST) ? '0 : owner + IDX_W'(1);
  assign tcnt_done = (tcnt == TCNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (win_any) next_state = ISSUE;
      ISSUE:     next_state = valid_op ? GAP : WAIT_RESP;
      WAIT_RESP: if (valid_op || tcnt_done) next_state = GAP;
      GAP:       next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Next-cycle values of the registered outputs; a response on the last wait
  // cycle takes priority over the timeout.
  always_comb begin
    gnt_d         = '0;
    valid_up_d    = 1'b0;
    rsp_valid_d   = '0;
    timeout_err_d = '0;
    stray_d       = 1'b0;
    capture_d     = 1'b0;
    case (state)
      IDLE: begin
        stray_d = valid_op;
        if (win_any) begin
          gnt_d      = win_oh;
          valid_up_d = 1'b1;
        end
      end
      ISSUE: begin
        if (valid_op) begin
          rsp_valid_d = owner_oh;
          capture_d   = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (valid_op) begin
          rsp_valid_d = owner_oh;
          capture_d   = 1'b1;
        end else if (tcnt_done) begin
          timeout_err_d = owner_oh;
        end
      end
      GAP: stray_d = valid_op;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt         <= '0;
      valid_up    <= 1'b0;
      rsp_valid   <= '0;
      timeout_err <= '0;
      stray_err   <= 1'b0;
      rsp_data    <= '0;
      data_ip     <= '0;
      busy        <= 1'b0;
      ptr         <= '0;
      owner       <= '0;
      tcnt        <= '0;
    end else begin
      gnt         <= gnt_d;
      valid_up    <= valid_up_d;
      rsp_valid   <= rsp_valid_d;
      timeout_err <= timeout_err_d;
      stray_err   <= stray_d && !stray_err;
      busy        <= (next_state != IDLE);
      if (capture_d) rsp_data <= data_op;
      if (state == IDLE && win_any) begin
        owner   <= win_idx;
        data_ip <= issue_pkt;
      end
      if (state == ISSUE) begin
        ptr  <= ptr_next;
        tcnt <= '0;
      end
      if (state == WAIT_RESP && next_state == WAIT_RESP) tcnt <= tcnt + TCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pds_arb.sv
// Scoreboard bench for pds_arb: transaction-level reference model pushes expected
// grants, outcomes and stray pulses; a negedge monitor pops and compares.
module tb_pds_arb;

  localparam int N = 4;
  localparam int T = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*16-1:0] pkt = '0;
  logic [N-1:0]    gnt, rsp_valid, timeout_err;
  logic [15:0]     rsp_data, data_ip;
  logic            stray_err, valid_up, busy;
  logic [15:0]     data_op = '0;
  logic            valid_op = 1'b0;

  pds_arb #(.N_REQ(N), .TIMEOUT(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .pkt         (pkt),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .timeout_err (timeout_err),
    .stray_err   (stray_err),
    .data_ip     (data_ip),
    .valid_up    (valid_up),
    .data_op     (data_op),
    .valid_op    (valid_op),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [N-1:0] vec;
    logic [15:0] data;
    bit          is_to;
  } ev_t;

  ev_t gq[$];
  ev_t oq[$];
  ev_t sq[$];

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic push_stray(input int c);
    ev_t e;
    e.cyc = c; e.vec = '0; e.data = '0; e.is_to = 1'b0;
    sq.push_back(e);
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (gnt != '0 || valid_up) begin
        check(gq.size() != 0, "gnt_unexpected", 32'(gnt), 32'(0));
        if (gq.size() != 0) begin
          e = gq.pop_front();
          check(cyc == e.cyc, "gnt_cycle", 32'(cyc), 32'(e.cyc));
          check(gnt == e.vec, "gnt_vec", 32'(gnt), 32'(e.vec));
          check(valid_up == 1'b1, "valid_up", 32'(valid_up), 32'(1));
          check(data_ip == e.data, "data_ip", 32'(data_ip), 32'(e.data));
        end
      end
      if (rsp_valid != '0 || timeout_err != '0) begin
        check(oq.size() != 0, "outcome_unexpected", 32'({rsp_valid, timeout_err}), 32'(0));
        if (oq.size() != 0) begin
          e = oq.pop_front();
          check(cyc == e.cyc, "outcome_cycle", 32'(cyc), 32'(e.cyc));
          if (e.is_to) begin
            check(timeout_err == e.vec, "timeout_err", 32'(timeout_err), 32'(e.vec));
            check(rsp_valid == '0, "rsp_on_timeout", 32'(rsp_valid), 32'(0));
          end else begin
            check(rsp_valid == e.vec, "rsp_valid", 32'(rsp_valid), 32'(e.vec));
            check(timeout_err == '0, "timeout_on_rsp", 32'(timeout_err), 32'(0));
            check(rsp_data == e.data, "rsp_data", 32'(rsp_data), 32'(e.data));
          end
        end
      end
      if (stray_err) begin
        check(sq.size() != 0, "stray_unexpected", 32'(stray_err), 32'(0));
        if (sq.size() != 0) begin
          e = sq.pop_front();
          check(cyc == e.cyc, "stray_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  endtask

  task automatic zero_check(input string tag);
    check(gnt == '0, {tag, "_gnt"}, 32'(gnt), 32'(0));
    check(valid_up == 1'b0, {tag, "_valid_up"}, 32'(valid_up), 32'(0));
    check(rsp_valid == '0, {tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    check(timeout_err == '0, {tag, "_timeout_err"}, 32'(timeout_err), 32'(0));
    check(stray_err == 1'b0, {tag, "_stray_err"}, 32'(stray_err), 32'(0));
    check(busy == 1'b0, {tag, "_busy"}, 32'(busy), 32'(0));
    check(data_ip == 16'h0000, {tag, "_data_ip"}, 32'(data_ip), 32'(0));
    check(rsp_data == 16'h0000, {tag, "_rsp_data"}, 32'(rsp_data), 32'(0));
  endtask

  // One packet: requests set in the current (idle) cycle, DUT answers n cycles
  // after valid_up (n > T means never). stray_mode 1 pulses valid_op in the
  // request cycle, 2 in the gap cycle.
  task automatic run_txn(input logic [N-1:0] rq, input logic [N*16-1:0] pk, input int n,
                         input logic [15:0] rd, input int stray_mode, input int idle_after);
    int          win, v, span;
    bit          respond;
    logic [15:0] wp;
    ev_t         e;
    check(busy == 1'b0, "busy_before_req", 32'(busy), 32'(0));
    win = -1;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (mptr + i) % N;
      if (win < 0 && rq[j]) win = j;
    end
    v  = cyc + 1;
    wp = pk[win*16 +: 16];
    wp[15:12] = 4'(win);
    e.cyc = v; e.vec = onehot(win); e.data = wp; e.is_to = 1'b0;
    gq.push_back(e);
    if (stray_mode == 1) begin
      valid_op = 1'b1;
      push_stray(cyc + 1);
    end
    req = rq;
    pkt = pk;
    tick();
    req = '0;
    valid_op = 1'b0;
    check(busy == 1'b1, "busy_in_issue", 32'(busy), 32'(1));
    respond = (n <= T);
    span = respond ? n + 1 : T + 1;
    for (int k = 0; k < span; k++) begin
      valid_op = respond && (k == n);
      data_op  = (respond && k == n) ? rd : 16'($urandom);
      tick();
    end
    e.cyc = v + span; e.vec = onehot(win); e.data = rd; e.is_to = !respond;
    oq.push_back(e);
    valid_op = (stray_mode == 2);
    data_op  = 16'($urandom);
    if (stray_mode == 2) push_stray(cyc + 1);
    tick();
    valid_op = 1'b0;
    mptr = (win + 1) % N;
    repeat (idle_after) tick();
  endtask

  function automatic logic [N*16-1:0] rand_pkts();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [N*16-1:0] pk;
    int n, sm, idle, r;
    fork
      monitor();
    join_none

    reset = 1'b1;
    repeat (3) tick();
    zero_check("reset");
    reset = 1'b0;
    tick();

    // Four requesters held, latency-1 DUT: grants 0,1,2,3,0 every 4 cycles.
    for (int i = 0; i < 5; i++) run_txn(4'hF, rand_pkts(), 1, 16'($urandom), 0, 0);

    pk = rand_pkts();
    pk[31:16] = 16'hF3A5;
    run_txn(4'b0010, pk, 2, 16'h1234, 0, 0);

    run_txn(4'hF, rand_pkts(), T + 1, 16'h0, 0, 0);
    run_txn(4'hF, rand_pkts(), 1, 16'($urandom), 0, 0);

    run_txn(4'hF, rand_pkts(), T, 16'hBEEF, 0, 1);
    run_txn(4'hF, rand_pkts(), 0, 16'hCAFE, 0, 1);

    valid_op = 1'b1;
    push_stray(cyc + 1);
    tick();
    valid_op = 1'b0;
    tick();
    run_txn(4'b1000, rand_pkts(), 3, 16'($urandom), 0, 0);

    // Reset one cycle after valid_up; the packet is abandoned silently.
    begin
      ev_t e;
      logic [15:0] wp;
      int win;
      win = -1;
      for (int i = 0; i < N; i++) begin
        int j;
        j = (mptr + i) % N;
        if (win < 0 && j == 2) win = j;
      end
      pk = rand_pkts();
      wp = pk[win*16 +: 16];
      wp[15:12] = 4'(win);
      e.cyc = cyc + 1; e.vec = onehot(win); e.data = wp; e.is_to = 1'b0;
      gq.push_back(e);
      req = 4'b0100;
      pkt = pk;
      tick();
      req = '0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      zero_check("midreset");
      mptr = 0;
      tick();
      valid_op = 1'b1;
      data_op  = 16'h5A5A;
      push_stray(cyc + 1);
      tick();
      valid_op = 1'b0;
      tick();
    end
    run_txn(4'hF, rand_pkts(), 1, 16'($urandom), 0, 0);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      n = $urandom_range(0, 4);
      else if (r < 8) n = $urandom_range(T - 1, T);
      else            n = T + 1;
      sm   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      idle = $urandom_range(0, 2);
      if (sm == 2 && idle == 0) idle = 1;
      run_txn(4'($urandom_range(1, 15)), rand_pkts(), n, 16'($urandom), sm, idle);
    end

    repeat (5) tick();
    check(gq.size() == 0, "gnt_missing", 32'(gq.size()), 32'(0));
    check(oq.size() == 0, "outcome_missing", 32'(oq.size()), 32'(0));
    check(sq.size() == 0, "stray_missing", 32'(sq.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
